// File: rtl/kitchen_countdown_if.sv
// Front-panel bus of the kitchen countdown timer: tick and button pulses in,
// BCD display digits and status flags out.
interface kitchen_countdown_if;
   logic       tick;
   logic       btn_min;
   logic       btn_sec;
   logic       btn_startstop;
   logic       btn_clear;
   logic [3:0] bin3;
   logic [3:0] bin2;
   logic [3:0] bin1;
   logic [3:0] bin0;
   logic       running;
   logic       alarm;

   modport master (
      output tick, btn_min, btn_sec, btn_startstop, btn_clear,
      input  bin3, bin2, bin1, bin0, running, alarm
   );

   modport slave (
      input  tick, btn_min, btn_sec, btn_startstop, btn_clear,
      output bin3, bin2, bin1, bin0, running, alarm
   );
endinterface

// File: rtl/kitchen_countdown.sv
// MM:SS kitchen countdown timer with button set-up, start/pause and a timed
// alarm that returns to IDLE on its own after ALARM_SECS ticks.
//
// state  | meaning
// IDLE   | setting time with btn_min/btn_sec; startstop starts if time nonzero
// RUN    | counting down one second per tick
// PAUSED | digits held, waiting for startstop to resume
// ALARM  | 00:00 reached; alarm high until ALARM_SECS ticks or a button
module kitchen_countdown #(
   parameter int ALARM_SECS = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   kitchen_countdown_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      ALARM  = 2'd3
   } state_t;

   localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] digits;
   logic [15:0] digits_nxt;
   logic [7:0]  alarm_cnt;
   logic [7:0]  alarm_cnt_nxt;
   logic        running_q;
   logic        alarm_q;
   logic        time_zero;
   logic        time_one;

   // Increment a two-digit BCD field 00..59 with wrap to 00.
   function automatic logic [7:0] inc59(input logic [7:0] f);
      logic [7:0] r;
      if (f[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (f[7:4] == 4'd5) ? 4'd0 : f[7:4] + 4'd1;
      end else begin
         r[7:4] = f[7:4];
         r[3:0] = f[3:0] + 4'd1;
      end
      return r;
   endfunction

   // Subtract one second from a nonzero MM:SS value with BCD borrow.
   function automatic logic [15:0] dec_mmss(input logic [15:0] t);
      logic [15:0] r;
      r = t;
      if (t[3:0] != 4'd0) begin
         r[3:0] = t[3:0] - 4'd1;
      end else begin
         r[3:0] = 4'd9;
         if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
         end else begin
            r[7:4] = 4'd5;
            if (t[11:8] != 4'd0) begin
               r[11:8] = t[11:8] - 4'd1;
            end else begin
               r[11:8]  = 4'd9;
               r[15:12] = t[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign time_zero = (digits == 16'h0000);
   assign time_one  = (digits == 16'h0001);

   always_comb begin
      state_nxt     = state;
      digits_nxt    = digits;
      alarm_cnt_nxt = alarm_cnt;
      case (state)
         IDLE: begin
            if (bus.btn_clear) begin
               digits_nxt = 16'h0000;
            end else if (bus.btn_startstop) begin
               if (!time_zero) state_nxt = RUN;
            end else begin
               if (bus.btn_min) digits_nxt[15:8] = inc59(digits[15:8]);
               if (bus.btn_sec) digits_nxt[7:0]  = inc59(digits[7:0]);
            end
         end
         RUN: begin
            if (bus.btn_clear) begin
               state_nxt  = IDLE;
               digits_nxt = 16'h0000;
            end else if (bus.btn_startstop) begin
               state_nxt = PAUSED;
            end else if (bus.tick) begin
               digits_nxt = dec_mmss(digits);
               if (time_one) begin
                  state_nxt     = ALARM;
                  alarm_cnt_nxt = ALARM_LOAD;
               end
            end
         end
         PAUSED: begin
            if (bus.btn_clear) begin
               state_nxt  = IDLE;
               digits_nxt = 16'h0000;
            end else if (bus.btn_startstop) begin
               state_nxt = RUN;
            end
         end
         ALARM: begin
            // Down-counter of remaining alarm ticks; terminal count at 1.
            if (bus.btn_clear || bus.btn_startstop) begin
               state_nxt     = IDLE;
               alarm_cnt_nxt = 8'd0;
            end else if (bus.tick) begin
               if (alarm_cnt <= 8'd1) begin
                  state_nxt     = IDLE;
                  alarm_cnt_nxt = 8'd0;
               end else begin
                  alarm_cnt_nxt = alarm_cnt - 8'd1;
               end
            end
         end
         default: begin
            state_nxt     = IDLE;
            digits_nxt    = 16'h0000;
            alarm_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         digits    <= 16'h0000;
         alarm_cnt <= 8'd0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         digits    <= digits_nxt;
         alarm_cnt <= alarm_cnt_nxt;
         running_q <= (state_nxt == RUN);
         alarm_q   <= (state_nxt == ALARM);
      end
   end

   assign bus.bin3    = digits[15:12];
   assign bus.bin2    = digits[11:8];
   assign bus.bin1    = digits[7:4];
   assign bus.bin0    = digits[3:0];
   assign bus.running = running_q;
   assign bus.alarm   = alarm_q;

endmodule

// File: doc/kitchen_countdown.md
KITCHEN_COUNTDOWN -- requirements
Module: kitchen_countdown

Interface
REQ-001 SHALL have parameter: ALARM_SECS, 10, number of tick pulses the alarm stays asserted before auto-return to IDLE (1..255).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: tick  input  1  one-clk-cycle enable pulse at 1 Hz, supplied by the clock divider.
REQ-005 SHALL have port: btn_min  input  1  debounced one-cycle pulse; add one minute.
REQ-006 SHALL have port: btn_sec  input  1  debounced one-cycle pulse; add one second.
REQ-007 SHALL have port: btn_startstop  input  1  debounced one-cycle pulse; start/pause toggle.
REQ-008 SHALL have port: btn_clear  input  1  debounced one-cycle pulse; clear/abort.
REQ-009 SHALL have ports: bin3, bin2, bin1, bin0  output  4 each  registered BCD digits: minutes tens, minutes units, seconds tens, seconds units; these feed the seven-segment display driver directly.
REQ-010 SHALL have port: running  output  1  registered; high only in RUN.
REQ-011 SHALL have port: alarm  output  1  registered; high only in ALARM.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSED, ALARM.
REQ-013 SHALL keep digits legal BCD at all times: bin3 0..5, bin2 0..9, bin1 0..5, bin0 0..9.
REQ-014 IDLE: btn_min SHALL increment the minute field BCD, 59 -> 00 wrap, seconds unaffected.
REQ-015 IDLE: btn_sec SHALL increment the second field BCD, 59 -> 00 wrap, no carry into minutes.
REQ-016 IDLE: btn_min and btn_sec in the same cycle SHALL both apply.
REQ-017 IDLE: btn_startstop SHALL go to RUN if time != 00:00; at 00:00 it SHALL be ignored.
REQ-018 RUN: each tick SHALL decrement the MM:SS value by one second with BCD borrow (e.g. 10:00 -> 09:59, 01:00 -> 00:59).
REQ-019 RUN: a tick at 00:01 SHALL produce 00:00 and enter ALARM in the same edge.
REQ-020 RUN: btn_startstop SHALL go to PAUSED with digits held; btn_min/btn_sec SHALL be ignored.
REQ-021 PAUSED: tick, btn_min, btn_sec SHALL be ignored; btn_startstop SHALL return to RUN; resumed count decrements on the next tick, no partial-second credit.
REQ-022 ALARM: digits SHALL hold 00:00; an internal 8-bit counter SHALL count ticks; after ALARM_SECS ticks the FSM SHALL enter IDLE and clear the counter.
REQ-023 ALARM: btn_startstop or btn_clear SHALL enter IDLE on the next edge; btn_min/btn_sec ignored.
REQ-024 btn_clear in RUN or PAUSED SHALL enter IDLE with digits 00:00; in IDLE it SHALL zero the digits.
REQ-025 Same-cycle priority SHALL be: reset > btn_clear > btn_startstop > btn_min/btn_sec > tick (e.g. tick with btn_startstop in RUN pauses without decrement).
REQ-026 All outputs SHALL update on the clock edge that samples the causing input (one-cycle latency, no combinational input-to-output path).
REQ-027 running and alarm SHALL be decoded from the registered state, never simultaneously high.

Reset
REQ-028 reset high at a rising edge SHALL force IDLE, bin3..bin0 = 0, running = 0, alarm = 0, alarm counter = 0, regardless of state or concurrent inputs.
REQ-029 reset mid-RUN or mid-ALARM SHALL abort with no further decrement or alarm tick.

Verification
REQ-030 Set: reset, 2x btn_min, 3x btn_sec -> 02:03 in IDLE; 60x btn_sec -> seconds wrap back to 03, minutes stay 02.
REQ-031 Borrow: load 01:00, start, one tick -> 00:59; running = 1.
REQ-032 Expiry: load 00:02, start, two ticks -> 00:00, alarm = 1, running = 0; ALARM_SECS further ticks -> alarm = 0, state IDLE.
REQ-033 Pause: load 00:10, start, 3 ticks -> 00:07; btn_startstop same cycle as tick -> 00:07 held; 5 ticks -> still 00:07; btn_startstop, 1 tick -> 00:06.
REQ-034 Guards: btn_startstop at 00:00 in IDLE -> stays IDLE; btn_clear with btn_startstop in RUN -> IDLE, 00:00.
REQ-035 Reset mid-operation: RUN at 05:30, reset with tick asserted -> 00:00, IDLE, running = 0 next cycle.
